mem_load_queue: RTL and testbench
=================================

MEM_LOAD_QUEUE -- requirements
Module: mem_load_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning maximum in-flight memory-stage entries (legal 1..8).
REQ-002 SHALL have parameter XLEN, default 32, meaning data/address width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  EX offers an instruction.
REQ-007 in_allowin  out  1  queue accepts in_valid this cycle.
REQ-008 in_pc  in  XLEN  instruction PC.
REQ-009 in_req_sent  in  1  EX issued a data-memory request for this instruction.
REQ-010 in_is_load  in  1  result comes from memory.
REQ-011 in_ld_size  in  2  0 byte, 1 half, 2 word.
REQ-012 in_ld_unsigned  in  1  zero-extend instead of sign-extend.
REQ-013 in_addr_lo  in  2  byte offset of access.
REQ-014 in_rf_we / in_rf_waddr / in_alu_result  in  1/5/XLEN  writeback control and non-load result.
REQ-015 data_ok / rdata  in  1/XLEN  in-order memory response.
REQ-016 flush  in  1  exception/ertn flush.
REQ-017 out_valid / out_allowin  out/in  1/1  handshake to WB.
REQ-018 out_pc / out_rf_we / out_rf_waddr / out_rf_wdata  out  XLEN/1/5/XLEN  retiring entry.
REQ-019 fwd_we / fwd_waddr / fwd_wdata / fwd_ready  out  DEPTH/5*DEPTH/XLEN*DEPTH/DEPTH  per-entry forwarding, slot 0 oldest.
REQ-020 protocol_err  out  1  sticky: data_ok with nothing outstanding.

Function
REQ-021 Entries SHALL be held in age order in a circular buffer; allocate on in_valid & in_allowin.
REQ-022 in_allowin SHALL be ~flush & (count<DEPTH | out_valid & out_allowin).
REQ-023 An entry SHALL be "waiting" iff in_req_sent & in_is_load & data not yet captured; stores with in_req_sent SHALL also wait for data_ok but capture no data.
REQ-024 data_ok SHALL be consumed first by discard_cnt (if >0, decrement, data dropped), else by the oldest waiting entry, else set protocol_err.
REQ-025 Captured rdata SHALL be aligned/extended: byte selected by addr_lo, half by addr_lo[1], word unchanged; sign-extend unless ld_unsigned.
REQ-026 out_valid SHALL be 1 iff head entry exists and is not waiting; earliest out_valid is one cycle after allocation or one cycle after its data_ok (registered capture, no combinational rdata path to outputs).
REQ-027 out_rf_wdata SHALL be the extended load data if is_load, else alu_result.
REQ-028 Head SHALL retire on out_valid & out_allowin; allocate and retire in the same cycle SHALL both take effect, count unchanged.
REQ-029 fwd_we[i] SHALL be entry-valid & rf_we; fwd_ready[i] SHALL be ~waiting; fwd_wdata[i] valid only when fwd_ready[i].
REQ-030 On flush, all entries SHALL be invalidated next cycle; discard_cnt SHALL become discard_cnt + (waiting entries incl. waiting stores) - (data_ok this cycle ? 1:0); incoming in_valid that cycle is dropped.
REQ-031 discard_cnt SHALL be width clog2(2*DEPTH+1) and never underflow; new entries allocated after flush SHALL receive data only after discard_cnt reaches 0.
REQ-032 Pointers SHALL wrap modulo DEPTH; DEPTH non-power-of-2 SHALL be supported.

Reset
REQ-033 While resetn=0: count, pointers, discard_cnt, protocol_err, all entry valid bits SHALL be 0; thus out_valid=0, fwd_we=0, in_allowin=1 (flush=0).
REQ-034 Reset mid-operation SHALL abandon outstanding responses without discard tracking (memory is reset together).

Structure
REQ-035 Package mem_pkg SHALL hold ld_size encoding constants and the entry record typedef.
REQ-036 Sub-module ld_align SHALL implement REQ-025 combinationally; queue control stays in mem_load_queue.

Verification
REQ-037 ld.b addr_lo=3, rdata=0x80FF_0000 -> out_rf_wdata=0xFFFF_FF80; ld.bu same -> 0x0000_0080.
REQ-038 DEPTH=2: two loads allocated back-to-back, out_allowin=0 -> third in_allowin=0; data_ok 0x11,0x22 -> retire order 0x11 then 0x22.
REQ-039 Two loads waiting, flush asserted -> discard_cnt=2; new load allocated; three data_ok (0xA,0xB,0xC) -> only 0xC written back.
REQ-040 flush coincident with data_ok, one waiting load -> discard_cnt=0; next data_ok fills new entry.
REQ-041 ALU op (alu_result=0x1234) behind waiting load -> fwd_ready=[0,1], out_valid=0 until load's data_ok.
REQ-042 data_ok with queue empty and discard_cnt=0 -> protocol_err=1, held until reset.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage load queue.
// Holds the load-size encoding and the per-entry control record. The data
// and PC payloads are kept outside the record so that they can follow the
// XLEN parameter of the queue instance.
package mem_pkg;

    // Load access size as driven by EX on in_ld_size
    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2
    } ld_size_e;

    // Control part of one in-flight memory-stage entry
    typedef struct packed {
        logic       valid;        // slot holds a live instruction
        logic       waiting;      // memory response still outstanding
        logic       is_load;      // result comes from memory
        logic [1:0] ld_size;      // ld_size_e encoding
        logic       ld_unsigned;  // zero-extend instead of sign-extend
        logic [1:0] addr_lo;      // byte offset of the access
        logic       rf_we;        // writes the register file
        logic [4:0] rf_waddr;     // destination register
    } mq_entry_t;

    localparam mq_entry_t MQ_ENTRY_NULL = '{
        valid:       1'b0,
        waiting:     1'b0,
        is_load:     1'b0,
        ld_size:     2'b00,
        ld_unsigned: 1'b0,
        addr_lo:     2'b00,
        rf_we:       1'b0,
        rf_waddr:    5'd0
    };

endpackage

// File: rtl/ld_align.sv
// Load data aligner: picks the addressed byte or half-word out of a raw
// memory word and sign- or zero-extends it to XLEN. Words pass unchanged.
// Ports:
//   rdata       in  XLEN  raw memory response word
//   ld_size     in  2     access size (LD_B / LD_H / LD_W)
//   ld_unsigned in  1     zero-extend when set
//   addr_lo     in  2     byte offset of the access
//   data        out XLEN  aligned and extended result
module ld_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      ld_size,
    input  logic            ld_unsigned,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed lane and extend it to the full register width
    always_comb begin
        byte_s = rdata[{addr_lo, 3'b000} +: 8];
        half_s = rdata[{addr_lo[1], 4'b0000} +: 16];
        case (ld_size)
            LD_B: data = ld_unsigned ? {{(XLEN-8){1'b0}}, byte_s}
                                     : {{(XLEN-8){byte_s[7]}}, byte_s};
            LD_H: data = ld_unsigned ? {{(XLEN-16){1'b0}}, half_s}
                                     : {{(XLEN-16){half_s[15]}}, half_s};
            LD_W: data = rdata;
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_load_queue.sv
// Memory-stage load queue. Keeps up to DEPTH instructions in age order
// between EX and WB, matches in-order data_ok responses to the oldest entry
// still waiting, and drops responses that belong to flushed instructions.
// Ports:
//   clk, resetn                       clock, asynchronous active-low reset
//   in_valid / in_allowin             EX -> queue handshake
//   in_pc, in_req_sent, in_is_load,
//   in_ld_size, in_ld_unsigned,
//   in_addr_lo, in_rf_we, in_rf_waddr,
//   in_alu_result                     instruction payload from EX
//   data_ok / rdata                   in-order memory response
//   flush                             exception/ertn flush
//   out_valid / out_allowin           queue -> WB handshake
//   out_pc, out_rf_we, out_rf_waddr,
//   out_rf_wdata                      retiring (head) entry
//   fwd_we/fwd_waddr/fwd_wdata/
//   fwd_ready                         per-age-slot forwarding, slot 0 oldest
//   protocol_err                      sticky: response with nothing outstanding
module mem_load_queue
    import mem_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_allowin,
    input  logic [XLEN-1:0]       in_pc,
    input  logic                  in_req_sent,
    input  logic                  in_is_load,
    input  logic [1:0]            in_ld_size,
    input  logic                  in_ld_unsigned,
    input  logic [1:0]            in_addr_lo,
    input  logic                  in_rf_we,
    input  logic [4:0]            in_rf_waddr,
    input  logic [XLEN-1:0]       in_alu_result,
    input  logic                  data_ok,
    input  logic [XLEN-1:0]       rdata,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_allowin,
    output logic [XLEN-1:0]       out_pc,
    output logic                  out_rf_we,
    output logic [4:0]            out_rf_waddr,
    output logic [XLEN-1:0]       out_rf_wdata,
    output logic [DEPTH-1:0]      fwd_we,
    output logic [5*DEPTH-1:0]    fwd_waddr,
    output logic [XLEN*DEPTH-1:0] fwd_wdata,
    output logic [DEPTH-1:0]      fwd_ready,
    output logic                  protocol_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = $clog2(2 * DEPTH + 1);

    mq_entry_t       ent_r  [DEPTH];
    logic [XLEN-1:0] data_r [DEPTH];   // alu_result at allocation, load data after capture
    logic [XLEN-1:0] pc_r   [DEPTH];
    logic [PW-1:0]   head_r;
    logic [PW-1:0]   tail_r;
    logic [CW-1:0]   count_r;
    logic [DW-1:0]   discard_r;        // responses still owed to flushed entries
    logic            protocol_err_r;

    logic [PW-1:0]   slot_idx_s [DEPTH];
    logic            wait_found_s;
    logic [PW-1:0]   wait_idx_s;
    logic [CW-1:0]   wait_cnt_s;
    logic            wait_is_load_s;
    logic [1:0]      wait_size_s;
    logic            wait_uns_s;
    logic [1:0]      wait_addr_s;
    logic [XLEN-1:0] aligned_s;
    logic            capture_s;
    logic            discard_dec_s;
    logic            proto_s;
    logic            retire_s;
    logic            alloc_s;
    logic [DW-1:0]   disc_sum_s;
    logic [DW-1:0]   disc_next_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PW'(DEPTH - 1)) r = {PW{1'b0}};
        else                     r = p + PW'(1'b1);
        return r;
    endfunction

    // Map age slot i (0 = oldest) onto its physical buffer index
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_idx_s[i] = PW'((int'(head_r) + i) % DEPTH);
        end
    end

    // Find the oldest waiting entry and count all waiting entries
    always_comb begin
        wait_found_s = 1'b0;
        wait_idx_s   = {PW{1'b0}};
        wait_cnt_s   = {CW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_r[slot_idx_s[i]].valid && ent_r[slot_idx_s[i]].waiting) begin
                wait_cnt_s = wait_cnt_s + CW'(1'b1);
                if (!wait_found_s) begin
                    wait_found_s = 1'b1;
                    wait_idx_s   = slot_idx_s[i];
                end else begin
                    wait_found_s = 1'b1;
                end
            end else begin
                wait_cnt_s = wait_cnt_s;
            end
        end
        wait_is_load_s = ent_r[wait_idx_s].is_load;
        wait_size_s    = ent_r[wait_idx_s].ld_size;
        wait_uns_s     = ent_r[wait_idx_s].ld_unsigned;
        wait_addr_s    = ent_r[wait_idx_s].addr_lo;
    end

    ld_align #(.XLEN(XLEN)) u_ld_align (
        .rdata       (rdata),
        .ld_size     (wait_size_s),
        .ld_unsigned (wait_uns_s),
        .addr_lo     (wait_addr_s),
        .data        (aligned_s)
    );

    // Response routing, handshakes and post-flush discard count
    always_comb begin
        // A response pays off flushed debt first, then the oldest waiter
        discard_dec_s = data_ok & (discard_r != {DW{1'b0}});
        capture_s     = data_ok & (discard_r == {DW{1'b0}}) & wait_found_s;
        proto_s       = data_ok & (discard_r == {DW{1'b0}}) & ~wait_found_s;
        out_valid     = ent_r[head_r].valid & ~ent_r[head_r].waiting;
        retire_s      = out_valid & out_allowin;
        in_allowin    = ~flush & ((count_r < CW'(DEPTH)) | retire_s);
        alloc_s       = in_valid & in_allowin;
        disc_sum_s    = discard_r + DW'(wait_cnt_s);
        if (data_ok && (disc_sum_s != {DW{1'b0}})) begin
            disc_next_s = disc_sum_s - DW'(1'b1);
        end else begin
            disc_next_s = disc_sum_s;
        end
    end

    // Head and forwarding views, all taken straight from registered state
    always_comb begin
        out_pc       = pc_r[head_r];
        out_rf_we    = ent_r[head_r].rf_we;
        out_rf_waddr = ent_r[head_r].rf_waddr;
        out_rf_wdata = data_r[head_r];
        protocol_err = protocol_err_r;
        fwd_we       = {DEPTH{1'b0}};
        fwd_ready    = {DEPTH{1'b0}};
        fwd_waddr    = {(5*DEPTH){1'b0}};
        fwd_wdata    = {(XLEN*DEPTH){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            fwd_we[i]                 = ent_r[slot_idx_s[i]].valid & ent_r[slot_idx_s[i]].rf_we;
            fwd_ready[i]              = ~ent_r[slot_idx_s[i]].waiting;
            fwd_waddr[5*i +: 5]       = ent_r[slot_idx_s[i]].rf_waddr;
            fwd_wdata[XLEN*i +: XLEN] = data_r[slot_idx_s[i]];
        end
    end

    // Queue state: allocate, capture, retire, flush and discard tracking
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_r[i]  <= MQ_ENTRY_NULL;
                data_r[i] <= {XLEN{1'b0}};
                pc_r[i]   <= {XLEN{1'b0}};
            end
            head_r         <= {PW{1'b0}};
            tail_r         <= {PW{1'b0}};
            count_r        <= {CW{1'b0}};
            discard_r      <= {DW{1'b0}};
            protocol_err_r <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_r[i].valid   <= 1'b0;
                ent_r[i].waiting <= 1'b0;
            end
            head_r         <= {PW{1'b0}};
            tail_r         <= {PW{1'b0}};
            count_r        <= {CW{1'b0}};
            discard_r      <= disc_next_s;
            protocol_err_r <= protocol_err_r | proto_s;
        end else begin
            protocol_err_r <= protocol_err_r | proto_s;
            if (discard_dec_s) begin
                discard_r <= discard_r - DW'(1'b1);
            end
            if (capture_s) begin
                ent_r[wait_idx_s].waiting <= 1'b0;
                if (wait_is_load_s) begin
                    data_r[wait_idx_s] <= aligned_s;
                end
            end
            if (retire_s) begin
                ent_r[head_r].valid <= 1'b0;
                head_r              <= ptr_inc(head_r);
            end
            // When full, tail equals head; this write overrides the retire clear
            if (alloc_s) begin
                ent_r[tail_r] <= '{
                    valid:       1'b1,
                    waiting:     in_req_sent,
                    is_load:     in_is_load,
                    ld_size:     in_ld_size,
                    ld_unsigned: in_ld_unsigned,
                    addr_lo:     in_addr_lo,
                    rf_we:       in_rf_we,
                    rf_waddr:    in_rf_waddr
                };
                data_r[tail_r] <= in_alu_result;
                pc_r[tail_r]   <= in_pc;
                tail_r         <= ptr_inc(tail_r);
            end
            case ({alloc_s, retire_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_load_queue.sv
// Self-checking bench for mem_load_queue (DEPTH=2, XLEN=32): table-driven
// alignment vectors, directed multi-cycle sequences, and a randomized run
// checked against a queue-based reference model.
module tb_mem_load_queue;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    logic                  clk;
    logic                  resetn;
    logic                  in_valid;
    logic                  in_allowin;
    logic [XLEN-1:0]       in_pc;
    logic                  in_req_sent;
    logic                  in_is_load;
    logic [1:0]            in_ld_size;
    logic                  in_ld_unsigned;
    logic [1:0]            in_addr_lo;
    logic                  in_rf_we;
    logic [4:0]            in_rf_waddr;
    logic [XLEN-1:0]       in_alu_result;
    logic                  data_ok;
    logic [XLEN-1:0]       rdata;
    logic                  flush;
    logic                  out_valid;
    logic                  out_allowin;
    logic [XLEN-1:0]       out_pc;
    logic                  out_rf_we;
    logic [4:0]            out_rf_waddr;
    logic [XLEN-1:0]       out_rf_wdata;
    logic [DEPTH-1:0]      fwd_we;
    logic [5*DEPTH-1:0]    fwd_waddr;
    logic [XLEN*DEPTH-1:0] fwd_wdata;
    logic [DEPTH-1:0]      fwd_ready;
    logic                  protocol_err;

    mem_load_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_allowin(in_allowin), .in_pc(in_pc),
        .in_req_sent(in_req_sent), .in_is_load(in_is_load),
        .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned),
        .in_addr_lo(in_addr_lo), .in_rf_we(in_rf_we),
        .in_rf_waddr(in_rf_waddr), .in_alu_result(in_alu_result),
        .data_ok(data_ok), .rdata(rdata), .flush(flush),
        .out_valid(out_valid), .out_allowin(out_allowin), .out_pc(out_pc),
        .out_rf_we(out_rf_we), .out_rf_waddr(out_rf_waddr),
        .out_rf_wdata(out_rf_wdata),
        .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
        .fwd_ready(fwd_ready), .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    typedef struct packed {
        logic [1:0]  sz;
        logic        uns;
        logic [1:0]  al;
        logic [31:0] rd;
        logic [31:0] exp;
    } avec_t;
    avec_t av [10];

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  waddr;
        logic        is_load;
        logic        waiting;
        logic [31:0] data;
        logic [1:0]  sz;
        logic        uns;
        logic [1:0]  al;
    } m_ent_t;
    m_ent_t mq [$];
    m_ent_t ne;
    int m_disc;
    int nwait;
    int kind;
    logic exp_ov;
    logic exp_allow;
    logic found;
    logic fwd_ok;
    logic [DEPTH-1:0] exp_we;
    logic [DEPTH-1:0] exp_rdy;
    logic [DEPTH-1:0] vmask;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_pc = 32'h0; in_req_sent = 1'b0; in_is_load = 1'b0;
        in_ld_size = 2'd0; in_ld_unsigned = 1'b0; in_addr_lo = 2'd0;
        in_rf_we = 1'b0; in_rf_waddr = 5'd0; in_alu_result = 32'h0;
        data_ok = 1'b0; rdata = 32'h0; flush = 1'b0; out_allowin = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        resetn = 1'b0;
        step();
        step();
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_fwd_we", fwd_we, 32'd0);
        check("rst_in_allowin", in_allowin, 32'd1);
        check("rst_protocol_err", protocol_err, 32'd0);
        resetn = 1'b1;
        step();
    endtask

    task automatic alloc(input logic sent, input logic ld, input logic [1:0] sz,
                         input logic uns, input logic [1:0] al, input logic [4:0] wa,
                         input logic [31:0] alu);
        in_valid = 1'b1; in_req_sent = sent; in_is_load = ld; in_ld_size = sz;
        in_ld_unsigned = uns; in_addr_lo = al; in_rf_we = 1'b1; in_rf_waddr = wa;
        in_alu_result = alu; in_pc = alu ^ 32'h1000_0000;
        step();
        in_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        data_ok = 1'b1; rdata = d;
        step();
        data_ok = 1'b0;
    endtask

    task automatic retire_one();
        out_allowin = 1'b1;
        step();
        out_allowin = 1'b0;
    endtask

    function automatic logic [31:0] m_align(input logic [31:0] d, input logic [1:0] sz,
                                            input logic uns, input logic [1:0] al);
        int unsigned v;
        if (sz == 2'd0) begin
            v = (d >> (8 * al)) & 32'hFF;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (d >> (16 * al[1])) & 32'hFFFF;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    initial begin
        n_pass = 0; n_total = 0;
        resetn = 1'b0;
        idle();

        av[0] = '{2'd0, 1'b0, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80};
        av[1] = '{2'd0, 1'b1, 2'd3, 32'h80FF_0000, 32'h0000_0080};
        av[2] = '{2'd0, 1'b0, 2'd2, 32'h80FF_0000, 32'hFFFF_FFFF};
        av[3] = '{2'd0, 1'b0, 2'd0, 32'h1234_567F, 32'h0000_007F};
        av[4] = '{2'd1, 1'b0, 2'd2, 32'h80FF_0000, 32'hFFFF_80FF};
        av[5] = '{2'd1, 1'b1, 2'd2, 32'h80FF_0000, 32'h0000_80FF};
        av[6] = '{2'd1, 1'b0, 2'd0, 32'h80FF_7001, 32'h0000_7001};
        av[7] = '{2'd2, 1'b0, 2'd0, 32'h80FF_0000, 32'h80FF_0000};
        av[8] = '{2'd1, 1'b0, 2'd1, 32'hAAAA_8001, 32'hFFFF_8001};
        av[9] = '{2'd0, 1'b0, 2'd1, 32'h0000_C300, 32'hFFFF_FFC3};

        apply_reset();

        // Alignment / extension vectors through the full queue path
        for (int k = 0; k < 10; k++) begin
            alloc(1'b1, 1'b1, av[k].sz, av[k].uns, av[k].al, 5'd5, 32'hDEAD_BEEF);
            check("align_wait", out_valid, 32'd0);
            respond(av[k].rd);
            check("align_valid", out_valid, 32'd1);
            check("align_data", out_rf_wdata, av[k].exp);
            retire_one();
        end

        // Full queue back-pressure and in-order retirement
        alloc(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 5'd1, 32'h0);
        alloc(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 5'd2, 32'h0);
        in_valid = 1'b1;
        #1;
        check("full_allowin", in_allowin, 32'd0);
        in_valid = 1'b0;
        respond(32'h11);
        respond(32'h22);
        check("order_valid0", out_valid, 32'd1);
        check("order_data0", out_rf_wdata, 32'h11);
        check("order_ready", fwd_ready, 32'h3);
        retire_one();
        check("order_valid1", out_valid, 32'd1);
        check("order_data1", out_rf_wdata, 32'h22);
        check("order_waddr1", out_rf_waddr, 32'd2);
        retire_one();
        check("order_empty", out_valid, 32'd0);

        // ALU result behind a waiting load
        alloc(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 5'd3, 32'h0);
        alloc(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd4, 32'h1234);
        check("alu_fwd_ready", fwd_ready, 32'h2);
        check("alu_fwd_we", fwd_we, 32'h3);
        check("alu_fwd_data", fwd_wdata[63:32], 32'h1234);
        check("alu_fwd_waddr", fwd_waddr[9:5], 32'd4);
        check("alu_blocked", out_valid, 32'd0);
        respond(32'h55);
        check("alu_load_valid", out_valid, 32'd1);
        check("alu_load_data", out_rf_wdata, 32'h55);
        retire_one();
        check("alu_data", out_rf_wdata, 32'h1234);
        check("alu_pc", out_pc, 32'h1000_1234);
        retire_one();

        // Flush with two waiting loads, then two responses discarded
        alloc(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 5'd1, 32'h0);
        alloc(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 5'd2, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_out_valid", out_valid, 32'd0);
        check("flush_fwd_we", fwd_we, 32'd0);
        alloc(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 5'd7, 32'h0);
        respond(32'hA);
        check("discard_a", out_valid, 32'd0);
        respond(32'hB);
        check("discard_b", out_valid, 32'd0);
        respond(32'hC);
        check("after_discard_valid", out_valid, 32'd1);
        check("after_discard_data", out_rf_wdata, 32'hC);
        check("after_discard_perr", protocol_err, 32'd0);
        retire_one();

        // Flush coinciding with the only pending response
        alloc(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 5'd1, 32'h0);
        flush = 1'b1; data_ok = 1'b1; rdata = 32'h99;
        step();
        flush = 1'b0; data_ok = 1'b0;
        alloc(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 5'd9, 32'h0);
        respond(32'h77);
        check("flush_ok_valid", out_valid, 32'd1);
        check("flush_ok_data", out_rf_wdata, 32'h77);
        retire_one();

        // Randomized run against the reference model
        apply_reset();
        mq.delete();
        m_disc = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            nwait = 0;
            foreach (mq[j]) if (mq[j].waiting) nwait++;
            kind = $urandom_range(0, 3);
            in_valid       = 1'($urandom_range(0, 1));
            in_req_sent    = (kind != 0);
            in_is_load     = (kind >= 2);
            in_ld_size     = 2'($urandom_range(0, 2));
            in_ld_unsigned = 1'($urandom_range(0, 1));
            in_addr_lo     = 2'($urandom_range(0, 3));
            in_rf_we       = ($urandom_range(0, 3) != 0);
            in_rf_waddr    = 5'($urandom);
            in_alu_result  = $urandom;
            in_pc          = $urandom;
            data_ok        = (m_disc + nwait > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            rdata          = $urandom;
            flush          = ($urandom_range(0, 19) == 0) && (m_disc + nwait <= 2 * DEPTH);
            out_allowin    = ($urandom_range(0, 3) != 0);
            #1;
            exp_ov    = (mq.size() > 0) && !mq[0].waiting;
            exp_allow = !flush && ((mq.size() < DEPTH) || (exp_ov && out_allowin));
            check("rnd_allowin", in_allowin, {31'd0, exp_allow});
            check("rnd_out_valid", out_valid, {31'd0, exp_ov});
            if (exp_ov) begin
                check("rnd_wdata", out_rf_wdata, mq[0].data);
                check("rnd_pc", out_pc, mq[0].pc);
                check("rnd_we_waddr", {out_rf_we, out_rf_waddr}, {mq[0].rf_we, mq[0].waddr});
            end
            exp_we = '0; exp_rdy = '0; vmask = '0; fwd_ok = 1'b1;
            for (int j = 0; j < DEPTH; j++) begin
                if (j < mq.size()) begin
                    vmask[j]   = 1'b1;
                    exp_we[j]  = mq[j].rf_we;
                    exp_rdy[j] = !mq[j].waiting;
                    if (!mq[j].waiting && fwd_wdata[32*j +: 32] !== mq[j].data) fwd_ok = 1'b0;
                    if (mq[j].rf_we && fwd_waddr[5*j +: 5] !== mq[j].waddr) fwd_ok = 1'b0;
                end
            end
            check("rnd_fwd_we", fwd_we, exp_we);
            check("rnd_fwd_ready", fwd_ready & vmask, exp_rdy);
            check("rnd_fwd_payload", fwd_ok, 32'd1);
            check("rnd_perr", protocol_err, 32'd0);

            if (flush) begin
                m_disc = m_disc + nwait - (data_ok ? 1 : 0);
                mq.delete();
            end else begin
                if (exp_ov && out_allowin) void'(mq.pop_front());
                if (data_ok) begin
                    if (m_disc > 0) begin
                        m_disc--;
                    end else begin
                        found = 1'b0;
                        foreach (mq[j]) begin
                            if (!found && mq[j].waiting) begin
                                mq[j].waiting = 1'b0;
                                if (mq[j].is_load)
                                    mq[j].data = m_align(rdata, mq[j].sz, mq[j].uns, mq[j].al);
                                found = 1'b1;
                            end
                        end
                    end
                end
                if (in_valid && exp_allow) begin
                    ne.pc = in_pc; ne.rf_we = in_rf_we; ne.waddr = in_rf_waddr;
                    ne.is_load = in_is_load; ne.waiting = in_req_sent;
                    ne.data = in_alu_result; ne.sz = in_ld_size;
                    ne.uns = in_ld_unsigned; ne.al = in_addr_lo;
                    mq.push_back(ne);
                end
            end
            step();
        end

        // Stray response sets a sticky error that only reset clears
        apply_reset();
        data_ok = 1'b1;
        step();
        data_ok = 1'b0;
        check("perr_set", protocol_err, 32'd1);
        step(); step(); step();
        check("perr_held", protocol_err, 32'd1);
        resetn = 1'b0;
        #1;
        check("perr_reset", protocol_err, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
